// File: rtl/lapido_pkg.sv
// -----------------------------------------------------------------------------
// lapido_pkg
// Shared definitions for the write-back stage:
//   - write-back FSM state encoding (WB_RUN / WB_LOAD)
//   - result-select constants (MXWB_ALU / MXWB_MEM)
//   - default datapath and register-address widths
//   - flag register width and bit positions ({O, S, C, Z})
// Optional feature macro used by wb_stage: WB_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
package lapido_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 5;

    typedef enum logic {
        WB_RUN  = 1'b0,
        WB_LOAD = 1'b1
    } wb_state_e;

    localparam logic MXWB_ALU = 1'b0;
    localparam logic MXWB_MEM = 1'b1;

    // Flag vector layout: [3]=O, [2]=S, [1]=C, [0]=Z
    localparam int FLAG_W = 4;
    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/wb_stage_flag_reg.sv
// -----------------------------------------------------------------------------
// flag_reg
// Architectural flag register with synchronous active-low reset and a write
// enable.
// Ports:
//   i_clk   - clock
//   i_rst_n - synchronous active-low reset (clears the register)
//   i_we    - write enable
//   i_d     - next flag value
//   o_q     - current flag value
// -----------------------------------------------------------------------------
module flag_reg #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage at the far end of the EX interface. Accepts one EX result
// per ex_valid/wb_ready handshake, drives the register-bank write port and
// owns the architectural flag register fed back to EX. Loads take one extra
// cycle because dm_Q arrives the cycle after the load is accepted.
// Ports:
//   CLK, RESET             - clock, synchronous active-low reset
//   ex_valid / wb_ready    - EX handshake
//   alu_result, alu_O/S/C/Z, tf_out, dm_Q - EX result, flags, condition, load data
//   uc_S_MXWB, uc_W_RB, uc_W_RF, uc_COND, uc_RD - write-back control
//   rb_W, rb_WA, rb_WD     - register-bank write port (rb_W is a one-cycle pulse)
//   rf_O/S/C/Z             - flag register
//   wb_retired             - completed-slot counter (only with WB_RETIRE_CNT_EN)
// Optional feature macro: WB_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
module wb_stage
    import lapido_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ex_valid,
    output logic          wb_ready,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_O,
    input  logic          alu_S,
    input  logic          alu_C,
    input  logic          alu_Z,
    input  logic          tf_out,
    input  logic [DW-1:0] dm_Q,
    input  logic          uc_S_MXWB,
    input  logic          uc_W_RB,
    input  logic          uc_W_RF,
    input  logic          uc_COND,
    input  logic [AW-1:0] uc_RD,
    output logic          rb_W,
    output logic [AW-1:0] rb_WA,
    output logic [DW-1:0] rb_WD,
    output logic          rf_O,
    output logic          rf_S,
    output logic          rf_C,
    output logic          rf_Z
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]   wb_retired
`endif
);

    wb_state_e         r_state;
    logic              r_rb_w;
    logic [AW-1:0]     r_rb_wa;
    logic [DW-1:0]     r_rb_wd;
    logic              r_hold_we;
    logic [AW-1:0]     r_hold_wa;

    logic              w_accept;
    logic              w_en;
    logic              w_rb_we;
    logic              w_load;
    logic              w_flag_we;
    logic [FLAG_W-1:0] w_alu_flags;
    logic [FLAG_W-1:0] w_rf_q;

    // wb_ready is gated by RESET so it reads 0 for the whole reset period.
    assign wb_ready    = RESET && (r_state == WB_RUN);
    assign w_accept    = ex_valid && wb_ready;
    assign w_en        = !uc_COND || tf_out;
    assign w_rb_we     = uc_W_RB && w_en;
    assign w_load      = (uc_S_MXWB == MXWB_MEM);
    // Loads never touch the flags; suppressed conditional ops neither.
    assign w_flag_we   = w_accept && uc_W_RF && w_en && !w_load;
    assign w_alu_flags = {alu_O, alu_S, alu_C, alu_Z};

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            // A pending load write is simply dropped here.
            r_state   <= WB_RUN;
            r_rb_w    <= 1'b0;
            r_rb_wa   <= '0;
            r_rb_wd   <= '0;
            r_hold_we <= 1'b0;
            r_hold_wa <= '0;
        end else begin
            // Strobe defaults low so it can only ever be a single-cycle pulse.
            r_rb_w <= 1'b0;
            case (r_state)
                WB_RUN: begin
                    if (w_accept) begin
                        if (w_load) begin
                            r_hold_we <= w_rb_we;
                            r_hold_wa <= uc_RD;
                            r_state   <= WB_LOAD;
                        end else begin
                            r_rb_w  <= w_rb_we;
                            r_rb_wa <= uc_RD;
                            r_rb_wd <= alu_result;
                        end
                    end
                end
                WB_LOAD: begin
                    // dm_Q is valid now, one cycle after the load was accepted.
                    r_rb_w  <= r_hold_we;
                    r_rb_wa <= r_hold_wa;
                    r_rb_wd <= dm_Q;
                    r_state <= WB_RUN;
                end
                default: r_state <= WB_RUN;
            endcase
        end
    end

    assign rb_W  = r_rb_w;
    assign rb_WA = r_rb_wa;
    assign rb_WD = r_rb_wd;

    flag_reg #(
        .W (FLAG_W)
    ) u_flag_reg (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_we    (w_flag_we),
        .i_d     (w_alu_flags),
        .o_q     (w_rf_q)
    );

    assign rf_O = w_rf_q[FLAG_O];
    assign rf_S = w_rf_q[FLAG_S];
    assign rf_C = w_rf_q[FLAG_C];
    assign rf_Z = w_rf_q[FLAG_Z];

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retired;
    logic        w_slot_done;

    // A slot completes on an ALU accept or on the LOAD->RUN edge; suppressed
    // conditional ops still count.
    assign w_slot_done = (w_accept && !w_load) || (r_state == WB_LOAD);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_retired <= '0;
        end else if (w_slot_done) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign wb_retired = r_retired;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage sitting at the far end of the EX interface. Accepts one EX result per handshake: ALU result, ALU flags, condition outcome and the data-memory read word. Drives the register-bank write port. Owns the architectural flag register whose `rf_O/S/C/Z` outputs feed back into EX's condition tester. Loads take an extra cycle because data-memory read data (`dm_Q`) arrives one cycle after the load leaves EX.

## Interface
Parameters:
- `DW`, 32: datapath width
- `AW`, 5: register-bank address width

Ports:
- `CLK` in 1: clock, all state updates on rising edge
- `RESET` in 1: synchronous, active-low reset
- `ex_valid` in 1: EX presents a result this cycle
- `wb_ready` out 1: stage can accept; transfer occurs when `ex_valid && wb_ready` at the rising edge
- `alu_result` in DW: ALU output
- `alu_O`, `alu_S`, `alu_C`, `alu_Z` in 1 each: ALU flags
- `tf_out` in 1: condition-test outcome from EX
- `dm_Q` in DW: data-memory read word, valid the cycle after a load is accepted
- `uc_S_MXWB` in 1: result select; 0 = ALU, 1 = memory (load)
- `uc_W_RB` in 1: register write requested
- `uc_W_RF` in 1: flag write requested
- `uc_COND` in 1: writes gated by `tf_out`
- `uc_RD` in AW: destination register
- `rb_W` out 1: register-bank write strobe
- `rb_WA` out AW: write address
- `rb_WD` out DW: write data
- `rf_O`, `rf_S`, `rf_C`, `rf_Z` out 1 each: flag register

## Operation
- Effective enable: `en = !uc_COND || tf_out`, sampled at accept.
- FSM states: `RUN`, `LOAD`.
- `RUN`: `wb_ready` = 1.
  - On accept with `uc_S_MXWB` = 0: latch `alu_result`, `uc_RD` and `uc_W_RB && en` into the output registers. Stay in `RUN`.
  - On accept with `uc_S_MXWB` = 1: latch `uc_RD` and `uc_W_RB && en` into holding registers. Go to `LOAD`.
- `LOAD`: `wb_ready` = 0 and `ex_valid` is ignored. At the next edge, capture `dm_Q` into `rb_WD`, drive `rb_W` and `rb_WA` from the holding registers, then return to `RUN`.
- Flags update at the accept edge only if `uc_W_RF && en && !uc_S_MXWB`. Loads never write flags.
- No special case for register 0. Writes to `uc_RD` = 0 pass through.
- `rb_W` is a one-cycle pulse. It is 0 in every cycle not following a completed write slot.

## Timing
- Reset (`RESET` = 0 at an edge): state `RUN`; `rb_W`, `rb_WA`, `rb_WD` and all `rf_*` = 0; `wb_ready` reads 0 while `RESET` is low and 1 from the first cycle after release.
- ALU op accepted at edge N: `rb_W/WA/WD` valid during cycle N+1. Flags visible from cycle N+1.
- Load accepted at edge N: `wb_ready` = 0 during cycle N+1. `dm_Q` is sampled at edge N+1. `rb_W` is high during cycle N+2. The next accept is at the earliest at edge N+2.
- Back-to-back ALU ops: one per cycle, with no bubble.
- Reset asserted while in `LOAD`: the pending write is dropped, the state goes to `RUN`, and `rb_W` stays 0.
- Conditional write with `tf_out` = 0: no register write and no flag write, but the transfer still completes.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - Adds output port `wb_retired` (32 bits). It increments by 1 at every edge that completes a slot: an ALU accept, or the `LOAD`→`RUN` transition. Suppressed conditional ops count too.
  - Reset value is 0. It wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `lapido_pkg` holds:
  - FSM state encoding (`WB_RUN` = 1'b0, `WB_LOAD` = 1'b1)
  - result-select constants `MXWB_ALU` = 0 and `MXWB_MEM` = 1
  - `DW`/`AW` defaults
- Sub-module `flag_reg`: a 4-bit register with synchronous active-low reset and a write enable. It is instantiated once and drives the `rf_*` outputs.

## Test plan
- Reset with all inputs high → `rb_W` = 0, `rf_*` = 0 and `wb_ready` = 0 while in reset; `wb_ready` = 1 in the cycle after release.
- ALU op `alu_result` = 0x00000003, `uc_RD` = 7, `uc_W_RB` = 1, `uc_W_RF` = 1, `alu_Z` = 0, `alu_C` = 1 → next cycle `rb_W` = 1, `rb_WA` = 7, `rb_WD` = 3, `rf_C` = 1, `rf_Z` = 0.
- Load to `uc_RD` = 2, with `dm_Q` = 0xDEADBEEF one cycle later → `wb_ready` = 0 for one cycle; `rb_W` = 1 and `rb_WD` = 0xDEADBEEF two cycles after accept; flags unchanged.
- `uc_COND` = 1 and `tf_out` = 0 with `uc_W_RB` = `uc_W_RF` = 1 → `rb_W` stays 0 and `rf_*` hold their previous values. Repeat with `tf_out` = 1 → the write occurs.
- Reset asserted in the `LOAD` cycle → no `rb_W` pulse follows; the next ALU op is accepted normally after release.
- With `WB_RETIRE_CNT_EN` defined: 3 ALU ops plus 1 load → `wb_retired` = 4. Preloaded at 0xFFFFFFFF, one more op → 0.
